distance_matrix_builder: RTL and testbench
==========================================

Name: distance_matrix_builder

Overview:
Downstream consumer of the coordinate collector. Once collection finishes, this block reads the N stored (x,y) points out of XMEM/YMEM and computes every pairwise distance. It writes the full NxN matrix into a distance RAM that the pathfinding core later reads. The datapath is pipelined at one matrix entry per clock within each row.

Parameters:
MAX_NODES, 16, maximum node count and the matrix row stride.
COORD_W, 8, width of each x/y coordinate.
ADDR_W, 4, log2(MAX_NODES), the node index width.
DIST_W, derived, COORD_W+1 by default; 2*COORD_W+1 when the optional feature is enabled.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that launches a build; driven from the collector's done output.
num_nodes  in  ADDR_W+1  node count N, sampled on start.
x_rd_addr  out  ADDR_W  XMEM read address.
x_rd_data  in  COORD_W  XMEM read data, valid 1 cycle after the address (synchronous RAM).
y_rd_addr  out  ADDR_W  YMEM read address; always equal to x_rd_addr.
y_rd_data  in  COORD_W  YMEM read data, same latency as x_rd_data.
dist_wr_addr  out  2*ADDR_W  distance RAM address, {i,j} (i*MAX_NODES+j).
dist_wr_data  out  DIST_W  distance value.
dist_wr_en  out  1  distance RAM write strobe.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle completion pulse.
error  out  1  sticky; set when N==0 or N>MAX_NODES; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, immediate): FSM goes to IDLE. All outputs are 0, including addresses, dist_wr_en, busy, done and error. The pipeline valid bits clear. Reset asserted mid-build abandons the build; no further writes occur.
- IDLE: on start=1, latch N.
  - If N is invalid: next cycle done=1, error=1, busy stays 0, return to IDLE.
  - Otherwise: clear error, set i=0, go to FETCH_I.
  - start is ignored in every other state.
- FETCH_I: drive rd_addr=i for one cycle, then go to LATCH_I.
- LATCH_I: capture xi, yi from the read data. Set j=0 and go to SCAN.
- SCAN: drive rd_addr=j each cycle with j incrementing. After issuing j=N-1, go to DRAIN.
- Pipeline: the read address for j is issued in cycle t. Data arrives in t+1, where |xi-xj| and |yi-yj| are computed and summed into an output register. dist_wr_en is high in cycle t+2 with addr {i,j}.
  - Write latency from address issue: exactly 2 cycles.
  - Within a row, writes are back-to-back for N consecutive cycles.
- DRAIN: 2 cycles to flush the pipeline. Then i++. If i==N go to DONE, else go to FETCH_I.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timing: each row takes N+4 cycles. done is high in cycle N*(N+4)+1 counted from the start-sampling edge (cycle 0).
- Arithmetic: absolute differences are unsigned COORD_W bits. The Manhattan sum is zero-extended to COORD_W+1 bits, so no overflow is possible. Diagonal entries (i==j) are written as 0 via normal computation.
- Only entries with i,j<N are written. Other matrix locations are untouched.

Optional Feature:
DIST_EUCLID_SQ_EN
- Defined: distance = dx*dx + dy*dy, DIST_W = 2*COORD_W+1. Pipeline depth and latency are unchanged; the multipliers sit in the t+1 stage.
- Undefined: Manhattan distance, DIST_W = COORD_W+1.

Decomposition:
- Package pathfinding_pkg holds:
  - MAX_NODES, COORD_W, ADDR_W;
  - the DIST_W localparam, under the macro;
  - the FSM state enum (IDLE, FETCH_I, LATCH_I, SCAN, DRAIN, DONE);
  - the matrix address concat helper function.
- Sub-module dist_calc: the registered stage taking xi, yi, xj, yj and producing the distance. Keeping it separate isolates the macro-dependent arithmetic.

Test Plan:
- N=3, points (0,0),(3,4),(10,1): 9 writes. Values: {0,1}=7, {0,2}=11, {1,2}=10, symmetric mirrors, diagonals 0. done at cycle 22. With the macro: {0,1}=25, {1,2}=58.
- N=1, point (255,255): exactly one write, {0,0}=0. done at cycle 6, error=0.
- N=2, points (0,0),(255,255): {0,1}=510 (9-bit max), with no truncation. Macro build gives 130050.
- N=0, then N=17: for each, done pulses next cycle with error=1, zero writes, busy stays 0. A following valid start clears error.
- start re-pulsed mid-build with N=16: the pulse is ignored. The original build completes all 256 writes, and N writes per row occur on consecutive cycles.
- reset_n pulled low during row 1 of an N=4 build: outputs are 0 immediately and no writes follow. A fresh start after reset completes normally.

Source files
------------

// File: rtl/pathfinding_pkg.sv
// Shared sizing, FSM states and matrix addressing for the distance matrix builder.
// DIST_EUCLID_SQ_EN selects squared-Euclidean distance (wider DIST_W) instead of Manhattan.
package pathfinding_pkg;

    localparam int MAX_NODES = 16;
    localparam int COORD_W   = 8;
    localparam int ADDR_W    = 4;

`ifdef DIST_EUCLID_SQ_EN
    localparam int DIST_W = 2 * COORD_W + 1;
`else
    localparam int DIST_W = COORD_W + 1;
`endif

    // One extra bit so a node count of MAX_NODES (and loop compares against it) fits.
    typedef logic [ADDR_W:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_I,
        LATCH_I,
        SCAN,
        DRAIN,
        DONE
    } state_e;

    function automatic logic [2*ADDR_W-1:0] mat_addr(input logic [ADDR_W-1:0] i,
                                                     input logic [ADDR_W-1:0] j);
        return {i, j};
    endfunction

endpackage

// File: rtl/dist_calc.sv
// Registered distance stage: |dx|+|dy| by default, dx*dx+dy*dy with DIST_EUCLID_SQ_EN.
module dist_calc
    import pathfinding_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic [COORD_W-1:0] xi_i,
    input  logic [COORD_W-1:0] yi_i,
    input  logic [COORD_W-1:0] xj_i,
    input  logic [COORD_W-1:0] yj_i,
    output logic [DIST_W-1:0]  dist_o
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [DIST_W-1:0]  dist_d;
    logic [DIST_W-1:0]  dist_q;

`ifdef DIST_EUCLID_SQ_EN
    logic [2*COORD_W-1:0] dx2;
    logic [2*COORD_W-1:0] dy2;
`endif

    always_comb begin
        dx = (xi_i >= xj_i) ? (xi_i - xj_i) : (xj_i - xi_i);
        dy = (yi_i >= yj_i) ? (yi_i - yj_i) : (yj_i - yi_i);
`ifdef DIST_EUCLID_SQ_EN
        dx2    = dx * dx;
        dy2    = dy * dy;
        dist_d = {1'b0, dx2} + {1'b0, dy2};
`else
        dist_d = {1'b0, dx} + {1'b0, dy};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dist_q <= '0;
        end else if (en_i) begin
            dist_q <= dist_d;
        end
    end

    assign dist_o = dist_q;

endmodule

// File: rtl/distance_matrix_builder.sv
// Reads N stored points and writes the full NxN pairwise distance matrix, one entry per clock per row.
// Distance metric is chosen by DIST_EUCLID_SQ_EN (see dist_calc).
module distance_matrix_builder
    import pathfinding_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W:0]     num_nodes,
    output logic [ADDR_W-1:0]   x_rd_addr,
    input  logic [COORD_W-1:0]  x_rd_data,
    output logic [ADDR_W-1:0]   y_rd_addr,
    input  logic [COORD_W-1:0]  y_rd_data,
    output logic [2*ADDR_W-1:0] dist_wr_addr,
    output logic [DIST_W-1:0]   dist_wr_data,
    output logic                dist_wr_en,
    output logic                busy,
    output logic                done,
    output logic                error,
    output state_e              state_dbg
);

    state_e             state_q, state_d;
    cnt_t               n_q, n_d;
    cnt_t               i_q, i_d;
    cnt_t               j_q, j_d;
    logic               drain_q, drain_d;
    logic               err_q, err_d;
    logic [COORD_W-1:0] xi_q, xi_d;
    logic [COORD_W-1:0] yi_q, yi_d;
    logic [ADDR_W-1:0]  rd_addr;

    // Pipeline tags: stage 1 = read data returning, stage 2 = distance registered.
    logic               v1_q, v2_q;
    logic [ADDR_W-1:0]  j1_q, j2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            xi_q    <= '0;
            yi_q    <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            j1_q    <= '0;
            j2_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            v1_q    <= (state_q == SCAN);
            v2_q    <= v1_q;
            j1_q    <= j_q[ADDR_W-1:0];
            j2_q    <= j1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        drain_d = drain_q;
        err_d   = err_q;
        xi_d    = xi_q;
        yi_d    = yi_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d = num_nodes;
                    if ((num_nodes == '0) || (num_nodes > cnt_t'(MAX_NODES))) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        i_d     = '0;
                        state_d = FETCH_I;
                    end
                end
            end
            FETCH_I: state_d = LATCH_I;
            LATCH_I: begin
                xi_d    = x_rd_data;
                yi_d    = y_rd_data;
                j_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if ((j_q + cnt_t'(1)) == n_q) begin
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    j_d = j_q + cnt_t'(1);
                end
            end
            DRAIN: begin
                // Second drain cycle is when the row's last write is on the bus.
                if (drain_q) begin
                    drain_d = 1'b0;
                    i_d     = i_q + cnt_t'(1);
                    state_d = ((i_q + cnt_t'(1)) == n_q) ? DONE : FETCH_I;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_addr = '0;
        if (state_q == FETCH_I) begin
            rd_addr = i_q[ADDR_W-1:0];
        end else if (state_q == SCAN) begin
            rd_addr = j_q[ADDR_W-1:0];
        end
    end

    dist_calc u_dist_calc (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (v1_q),
        .xi_i    (xi_q),
        .yi_i    (yi_q),
        .xj_i    (x_rd_data),
        .yj_i    (y_rd_data),
        .dist_o  (dist_wr_data)
    );

    assign x_rd_addr    = rd_addr;
    assign y_rd_addr    = rd_addr;
    assign dist_wr_addr = mat_addr(i_q[ADDR_W-1:0], j2_q);
    assign dist_wr_en   = v2_q;
    assign busy         = (state_q == FETCH_I) || (state_q == LATCH_I) ||
                          (state_q == SCAN)    || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign error        = err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_distance_matrix_builder.sv
// Scoreboard bench for distance_matrix_builder: reference model fills queues, a monitor checks at negedge.
module tb_distance_matrix_builder;
  import pathfinding_pkg::*;

  localparam int AW2 = 2 * ADDR_W;
  localparam int EW  = AW2 + DIST_W;

  typedef struct {
    longint cyc;
    bit     err;
  } done_t;

  typedef struct {
    logic [AW2-1:0] addr;
    longint         val;
  } spot_t;

  // ---------------- clock / reset / DUT ----------------
  logic               clk;
  logic               reset_n;
  logic               start;
  logic [ADDR_W:0]    num_nodes;
  logic [ADDR_W-1:0]  x_rd_addr;
  logic [COORD_W-1:0] x_rd_data;
  logic [ADDR_W-1:0]  y_rd_addr;
  logic [COORD_W-1:0] y_rd_data;
  logic [AW2-1:0]     dist_wr_addr;
  logic [DIST_W-1:0]  dist_wr_data;
  logic               dist_wr_en;
  logic               busy;
  logic               done;
  logic               error;
  state_e             state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  distance_matrix_builder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .num_nodes    (num_nodes),
    .x_rd_addr    (x_rd_addr),
    .x_rd_data    (x_rd_data),
    .y_rd_addr    (y_rd_addr),
    .y_rd_data    (y_rd_data),
    .dist_wr_addr (dist_wr_addr),
    .dist_wr_data (dist_wr_data),
    .dist_wr_en   (dist_wr_en),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  // Point memories with one-cycle synchronous read.
  logic [COORD_W-1:0] xmem [MAX_NODES];
  logic [COORD_W-1:0] ymem [MAX_NODES];
  always @(posedge clk) begin
    x_rd_data <= xmem[x_rd_addr];
    y_rd_data <= ymem[y_rd_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  done_t         done_q[$];
  spot_t         spot_q[$];
  logic [DIST_W-1:0] dram [1 << AW2];
  longint busy_lo = 1;
  longint busy_hi = 0;
  longint last_wr_cyc = 0;
  bit     flush_req = 0;
  bit     end_req = 0;
  bit     end_done = 0;
  int     n_vec = 0;
  int     n_err = 0;

  function automatic longint ref_dist(input int x1, input int y1, input int x2, input int y2);
    int dx;
    int dy;
    dx = (x1 > x2) ? x1 - x2 : x2 - x1;
    dy = (y1 > y2) ? y1 - y2 : y2 - y1;
`ifdef DIST_EUCLID_SQ_EN
    return longint'(dx * dx + dy * dy);
`else
    return longint'(dx + dy);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    done_t d;
    spot_t s;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_outputs_zero",
              64'({x_rd_addr, y_rd_addr, dist_wr_addr, dist_wr_data, dist_wr_en, busy, done, error}),
              64'd0);
      end
      if (flush_req) begin
        exp_q.delete();
        done_q.delete();
      end
      check("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (busy) check("error_cleared", 64'(error), 64'd0);
      if (dist_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(dist_wr_addr), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(dist_wr_addr), 64'(e[EW-1:DIST_W]));
          check("wr_data", 64'(dist_wr_data), 64'(e[DIST_W-1:0]));
        end
        if (dist_wr_addr[ADDR_W-1:0] != '0) check("row_back_to_back", 64'(cyc - last_wr_cyc), 64'd1);
        last_wr_cyc = cyc;
        dram[dist_wr_addr] = dist_wr_data;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cyc));
          check("done_error", 64'(error), 64'(d.err));
          check("writes_outstanding_at_done", 64'(exp_q.size()), 64'd0);
        end
      end
      while (spot_q.size() > 0) begin
        s = spot_q.pop_front();
        check("matrix_entry", 64'(dram[s.addr]), 64'(s.val));
      end
      if (end_req && !end_done) begin
        end_done = 1;
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
        check("all_dones_seen", 64'(done_q.size()), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pt(input int idx, input int x, input int y);
    xmem[idx] = COORD_W'(x);
    ymem[idx] = COORD_W'(y);
  endtask

  task automatic rand_pts();
    for (int k = 0; k < MAX_NODES; k++) set_pt(k, $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic spot(input int i, input int j, input longint val);
    spot_t s;
    s.addr = AW2'(i * MAX_NODES + j);
    s.val  = val;
    spot_q.push_back(s);
  endtask

  // restart_at / reset_at: negedge index after start at which to re-pulse start or assert reset (-1 = never).
  task automatic build(input int n, input int restart_at, input int reset_at);
    longint c0;
    bit     ok;
    int     bound;
    done_t  d;
    ok = (n >= 1) && (n <= MAX_NODES);
    if (ok) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          exp_q.push_back({AW2'(i * MAX_NODES + j),
                           DIST_W'(ref_dist(int'(xmem[i]), int'(ymem[i]), int'(xmem[j]), int'(ymem[j])))});
    end
    @(negedge clk);
    start = 1'b1;
    num_nodes = cnt_t'(n);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    if (ok) begin
      busy_lo = c0;
      busy_hi = c0 + longint'(n * (n + 4)) - 1;
      d.cyc = c0 + longint'(n * (n + 4));
      d.err = 1'b0;
    end else begin
      d.cyc = c0;
      d.err = 1'b1;
    end
    done_q.push_back(d);
    bound = ok ? n * (n + 4) + 8 : 8;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (k == reset_at) begin
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        flush_req = 1'b1;
        busy_lo = 1;
        busy_hi = 0;
        break;
      end
      start = (k == restart_at);
      if (k == restart_at) num_nodes = cnt_t'(5);
      if (done) break;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    num_nodes = '0;
    for (int k = 0; k < MAX_NODES; k++) set_pt(k, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Small hand-checked triangle.
    set_pt(0, 0, 0);
    set_pt(1, 3, 4);
    set_pt(2, 10, 1);
    build(3, -1, -1);
`ifdef DIST_EUCLID_SQ_EN
    spot(0, 1, 25); spot(1, 0, 25); spot(1, 2, 58); spot(0, 2, 101);
`else
    spot(0, 1, 7); spot(1, 0, 7); spot(1, 2, 10); spot(0, 2, 11);
`endif
    spot(2, 2, 0);

    // Single node at the coordinate maximum.
    set_pt(0, 255, 255);
    build(1, -1, -1);
    spot(0, 0, 0);

    // Widest possible distance.
    set_pt(0, 0, 0);
    set_pt(1, 255, 255);
    build(2, -1, -1);
`ifdef DIST_EUCLID_SQ_EN
    spot(0, 1, 130050); spot(1, 0, 130050);
`else
    spot(0, 1, 510); spot(1, 0, 510);
`endif

    // Invalid counts, then a valid build that must clear error.
    build(0, -1, -1);
    build(17, -1, -1);
    rand_pts();
    build(3, -1, -1);

    // Full-size build with an ignored mid-build start.
    rand_pts();
    build(16, 50, -1);

    // Reset during row 1 of an N=4 build, then a clean rebuild.
    rand_pts();
    build(4, -1, 11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    flush_req = 1'b0;
    repeat (6) @(negedge clk);
    build(4, -1, -1);

    // Random sizes and points.
    for (int r = 0; r < 3; r++) begin
      rand_pts();
      build($urandom_range(1, MAX_NODES), -1, -1);
    end

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
